// File: rtl/dds_freq_sweep_pkg.sv
// dds_freq_sweep_pkg: shared sweep state encoding and mode constants
package dds_freq_sweep_pkg;

    typedef enum logic [1:0] {
        SWP_IDLE = 2'd0,
        SWP_UP   = 2'd1,
        SWP_DOWN = 2'd2,
        SWP_HOLD = 2'd3
    } swp_state_t;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_TRI    = 1'b1;

endpackage

// File: rtl/dds_sweep_step.sv
// dds_sweep_step: one clamped step of the frequency word toward a bound, no wrap-around
module dds_sweep_step #(
    parameter int W = 16
) (
    input  logic [W-1:0] cur,
    input  logic [W-1:0] step,
    input  logic [W-1:0] bound,
    input  logic         dir,
    output logic [W-1:0] nxt,
    output logic         hit
);

    logic [W:0] sum;
    logic [W:0] dif;

    // One extra bit catches overflow upward and borrow downward so both clamp to the bound
    always_comb begin
        sum = {1'b0, cur} + {1'b0, step};
        dif = {1'b0, cur} - {1'b0, step};
        nxt = dir ? ((sum >= {1'b0, bound}) ? bound : sum[W-1:0])
                  : ((dif[W] || dif[W-1:0] <= bound) ? bound : dif[W-1:0]);
        hit = (nxt == bound);
    end

endmodule

// File: rtl/dds_freq_sweep.sv
// dds_freq_sweep: single-shot / triangle chirp generator feeding a DDS phase accumulator
module dds_freq_sweep
    import dds_freq_sweep_pkg::*;
#(
    parameter int PHASE_INC_WIDTH = 16,
    parameter int PHASE_ACC_WIDTH = 16,
    parameter int DWELL_WIDTH     = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    input  logic                       stop_i,
    input  logic                       mode_i,
    input  logic                       sync_phase_i,
    input  logic [PHASE_INC_WIDTH-1:0] f_start_i,
    input  logic [PHASE_INC_WIDTH-1:0] f_stop_i,
    input  logic [PHASE_INC_WIDTH-1:0] f_step_i,
    input  logic [DWELL_WIDTH-1:0]     dwell_i,
    output logic [PHASE_INC_WIDTH-1:0] phase_inc_o,
    output logic                       phase_inc_ena_o,
    output logic [PHASE_ACC_WIDTH-1:0] phase_load_o,
    output logic                       phase_load_ena_o,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int W = PHASE_INC_WIDTH;

    swp_state_t           state;
    logic [W-1:0]         cfg_start;
    logic [W-1:0]         cfg_stop;
    logic [W-1:0]         cfg_step;
    logic [DWELL_WIDTH-1:0] cfg_dwell;
    logic                 cfg_mode;
    logic [DWELL_WIDTH-1:0] cnt;
    logic [W-1:0]         hi;
    logic [W-1:0]         lo;
    logic [W-1:0]         bound;
    logic [W-1:0]         nxt;
    logic                 dir;
    logic                 hit;

    assign phase_load_o = '0;

    // Direction of the next step: triangle turns around once an endpoint value has finished its dwell
    always_comb begin
        hi    = (cfg_stop > cfg_start) ? cfg_stop : cfg_start;
        lo    = (cfg_stop > cfg_start) ? cfg_start : cfg_stop;
        dir   = (cfg_mode == MODE_TRI) ? ((state == SWP_UP && phase_inc_o != hi) || (state == SWP_DOWN && phase_inc_o == lo))
                                       : (state == SWP_UP);
        bound = dir ? hi : lo;
    end

    dds_sweep_step #(.W(W)) u_step (
        .cur   (phase_inc_o),
        .step  (cfg_step),
        .bound (bound),
        .dir   (dir),
        .nxt   (nxt),
        .hit   (hit)
    );

    // Sweep FSM with dwell counter, latched configuration and registered outputs
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state            <= SWP_IDLE;
            cfg_start        <= '0;
            cfg_stop         <= '0;
            cfg_step         <= '0;
            cfg_dwell        <= '0;
            cfg_mode         <= MODE_SINGLE;
            cnt              <= '0;
            phase_inc_o      <= '0;
            phase_inc_ena_o  <= 1'b0;
            phase_load_ena_o <= 1'b0;
            busy_o           <= 1'b0;
            done_o           <= 1'b0;
        end else begin
            phase_load_ena_o <= 1'b0;
            done_o           <= 1'b0;
            if (stop_i) begin
                state           <= SWP_IDLE;
                phase_inc_ena_o <= 1'b0;
                busy_o          <= 1'b0;
            end else if (start_i) begin
                cfg_start        <= f_start_i;
                cfg_stop         <= f_stop_i;
                cfg_step         <= (f_step_i == '0) ? W'(1) : f_step_i;
                cfg_dwell        <= dwell_i;
                cfg_mode         <= mode_i;
                cnt              <= dwell_i;
                phase_inc_o      <= f_start_i;
                phase_inc_ena_o  <= 1'b1;
                phase_load_ena_o <= sync_phase_i;
                if (f_stop_i > f_start_i || (f_stop_i == f_start_i && mode_i == MODE_TRI)) begin
                    state  <= SWP_UP;
                    busy_o <= 1'b1;
                end else if (f_stop_i < f_start_i) begin
                    state  <= SWP_DOWN;
                    busy_o <= 1'b1;
                end else begin
                    state  <= SWP_HOLD;
                    busy_o <= 1'b0;
                    done_o <= 1'b1;
                end
            end else if (state == SWP_UP || state == SWP_DOWN) begin
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else begin
                    cnt         <= cfg_dwell;
                    phase_inc_o <= nxt;
                    if (cfg_mode == MODE_SINGLE && hit) begin
                        state  <= SWP_HOLD;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end else begin
                        state <= dir ? SWP_UP : SWP_DOWN;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dds_freq_sweep.sv
// tb_dds_freq_sweep: scoreboard bench for the chirp generator against a sweep-plan model
module tb_dds_freq_sweep;

    typedef struct packed {
        logic [15:0] inc;
        logic        ena;
        logic        ld;
        logic        busy;
        logic        done;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic        stop_i = 1'b0;
    logic        mode_i = 1'b0;
    logic        sync_phase_i = 1'b0;
    logic [15:0] f_start_i = '0;
    logic [15:0] f_stop_i = '0;
    logic [15:0] f_step_i = '0;
    logic [15:0] dwell_i = '0;
    logic [15:0] phase_inc_o;
    logic        phase_inc_ena_o;
    logic [15:0] phase_load_o;
    logic        phase_load_ena_o;
    logic        busy_o;
    logic        done_o;

    int total = 0;
    int bad = 0;

    exp_t q[$];

    logic        c_mode = 1'b0;
    logic        c_sync = 1'b0;
    logic [15:0] c_fs = '0;
    logic [15:0] c_fe = '0;
    logic [15:0] c_st = '0;
    logic [15:0] c_dw = '0;

    int plan[$];
    int pidx = 0;
    bit m_tri = 1'b0;
    int m_state = 0;
    logic [15:0] m_cur = '0;
    logic m_ena = 1'b0;

    always #5 clk_i = ~clk_i;

    dds_freq_sweep dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .start_i          (start_i),
        .stop_i           (stop_i),
        .mode_i           (mode_i),
        .sync_phase_i     (sync_phase_i),
        .f_start_i        (f_start_i),
        .f_stop_i         (f_stop_i),
        .f_step_i         (f_step_i),
        .dwell_i          (dwell_i),
        .phase_inc_o      (phase_inc_o),
        .phase_inc_ena_o  (phase_inc_ena_o),
        .phase_load_o     (phase_load_o),
        .phase_load_ena_o (phase_load_ena_o),
        .busy_o           (busy_o),
        .done_o           (done_o)
    );

    // Clamped walk from a to b, each value repeated rep times, final b optionally omitted
    function automatic void add_path(input int a, input int b, input int st, input int rep, input bit drop_last);
        int v = a;
        while (v != b) begin
            for (int k = 0; k < rep; k++) plan.push_back(v);
            v = (b > a) ? ((v + st > b) ? b : v + st) : ((v - st < b) ? b : v - st);
        end
        if (!drop_last) for (int k = 0; k < rep; k++) plan.push_back(b);
    endfunction

    function automatic bit advance();
        m_cur = 16'(m_tri ? plan[pidx % plan.size()] : plan[pidx]);
        if (!m_tri && pidx == plan.size() - 1) begin
            m_state = 2;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // Expected outputs after the coming clock edge for the controls just applied
    function automatic void model_step(input bit r, input bit s, input bit p);
        exp_t e;
        int st;
        e = '0;
        if (!r) begin
            m_state = 0;
            m_cur = '0;
            m_ena = 1'b0;
        end else if (p) begin
            m_state = 0;
            m_ena = 1'b0;
        end else if (s) begin
            st = (c_st == 0) ? 1 : int'(c_st);
            m_tri = c_mode;
            plan.delete();
            if (!m_tri) begin
                add_path(int'(c_fs), int'(c_fe), st, int'(c_dw) + 1, 1'b1);
                plan.push_back(int'(c_fe));
            end else if (c_fs == c_fe) begin
                plan.push_back(int'(c_fs));
            end else begin
                add_path(int'(c_fs), int'(c_fe), st, int'(c_dw) + 1, 1'b1);
                add_path(int'(c_fe), int'(c_fs), st, int'(c_dw) + 1, 1'b1);
            end
            pidx = 0;
            m_ena = 1'b1;
            m_state = 1;
            e.ld = c_sync;
            e.done = advance();
        end else if (m_state == 1) begin
            pidx++;
            e.done = advance();
        end
        e.inc = m_cur;
        e.ena = m_ena;
        e.busy = (m_state == 1);
        q.push_back(e);
    endfunction

    task automatic tick(input bit r, input bit s, input bit p);
        @(negedge clk_i);
        mode_i = c_mode;
        sync_phase_i = c_sync;
        f_start_i = c_fs;
        f_stop_i = c_fe;
        f_step_i = c_st;
        dwell_i = c_dw;
        rst_ni = r;
        start_i = s;
        stop_i = p;
        model_step(r, s, p);
    endtask

    task automatic cfg(input bit m, input bit sy, input logic [15:0] fs, input logic [15:0] fe, input logic [15:0] st, input logic [15:0] dw);
        c_mode = m;
        c_sync = sy;
        c_fs = fs;
        c_fe = fe;
        c_st = st;
        c_dw = dw;
    endtask

    task automatic rand_cfg();
        int d;
        int sel;
        c_mode = 1'($urandom);
        c_sync = 1'($urandom);
        c_dw = 16'($urandom_range(0, 3));
        c_fs = 16'($urandom_range(0, 65535));
        sel = $urandom_range(0, 5);
        if (sel == 0) begin
            c_fe = c_fs;
            c_st = 16'($urandom);
        end else if (sel == 1) begin
            c_st = '0;
            c_fe = (c_fs > 100) ? c_fs - 16'($urandom_range(1, 20)) : c_fs + 16'($urandom_range(1, 20));
        end else begin
            c_fe = 16'($urandom_range(0, 65535));
            d = (c_fe > c_fs) ? int'(c_fe) - int'(c_fs) : int'(c_fs) - int'(c_fe);
            c_st = (sel == 2) ? 16'($urandom_range(32768, 65535)) : 16'(d / $urandom_range(1, 20) + $urandom_range(0, 2));
        end
    endtask

    // Monitor: every cycle the DUT presents registered outputs, compare against the oldest expectation
    initial begin
        exp_t e;
        logic [19:0] act;
        forever begin
            @(posedge clk_i);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                act = {phase_inc_o, phase_inc_ena_o, phase_load_ena_o, busy_o, done_o};
                total++;
                if (act !== e || phase_load_o !== 16'h0) begin
                    bad++;
                    $display("FAIL cyc t=%0t got inc=%h ena=%b ld=%b busy=%b done=%b load=%h want inc=%h ena=%b ld=%b busy=%b done=%b load=0000",
                             $time, phase_inc_o, phase_inc_ena_o, phase_load_ena_o, busy_o, done_o, phase_load_o,
                             e.inc, e.ena, e.ld, e.busy, e.done);
                end
            end
        end
    end

    // Stimulus: directed scenarios, then random sweeps with stops, restarts and resets
    initial begin
        repeat (3) tick(1'b0, 1'b0, 1'b0);
        cfg(1'b0, 1'b0, 16'd100, 16'd140, 16'd10, 16'd2);
        tick(1'b1, 1'b1, 1'b0);
        repeat (18) tick(1'b1, 1'b0, 1'b0);
        cfg(1'b0, 1'b1, 16'hFFF0, 16'h0005, 16'h4000, 16'd0);
        tick(1'b1, 1'b1, 1'b0);
        repeat (7) tick(1'b1, 1'b0, 1'b0);
        cfg(1'b1, 1'b0, 16'd10, 16'd30, 16'd10, 16'd0);
        tick(1'b1, 1'b1, 1'b0);
        repeat (12) tick(1'b1, 1'b0, 1'b0);
        cfg(1'b0, 1'b0, 16'd50, 16'd53, 16'd0, 16'd1);
        tick(1'b1, 1'b1, 1'b0);
        repeat (10) tick(1'b1, 1'b0, 1'b0);
        cfg(1'b0, 1'b1, 16'd7, 16'd7, 16'd3, 16'd0);
        tick(1'b1, 1'b1, 1'b0);
        repeat (3) tick(1'b1, 1'b0, 1'b0);
        cfg(1'b0, 1'b0, 16'd0, 16'd1000, 16'd1, 16'd0);
        tick(1'b1, 1'b1, 1'b0);
        repeat (5) tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        repeat (3) tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b1);
        repeat (2) tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        repeat (4) tick(1'b1, 1'b0, 1'b0);
        cfg(1'b1, 1'b1, 16'd500, 16'd480, 16'd7, 16'd1);
        tick(1'b1, 1'b1, 1'b0);
        repeat (12) tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        repeat (3) tick(1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 120; n++) begin
            rand_cfg();
            tick(1'b1, 1'b1, 1'b0);
            for (int c = $urandom_range(1, 60); c > 0; c--) begin
                int ev;
                ev = $urandom_range(0, 99);
                if (ev >= 5) rand_cfg();
                tick(ev != 0, ev == 1 || ev == 3, ev == 2 || ev == 3);
            end
        end
        tick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk_i);
        #2;
        if (q.size() > 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
